// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared widths, encodings and fetch state type
package riscv_pkg;

    localparam int XLEN = 64;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - instruction/PC queue with flush; head outputs read zero when empty
module fetch_fifo #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic [XLEN-1:0]          push_pc,
    input  logic [31:0]              push_instr,
    input  logic                     pop,
    output logic                     valid,
    output logic [XLEN-1:0]          head_pc,
    output logic [31:0]              head_instr,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [31:0]     instr_mem [DEPTH];
    logic            do_push;
    logic            do_pop;

    // Flush wins over both ports so a redirect never lets stale entries through.
    assign do_pop  = pop && valid && !flush;
    assign do_push = push && !flush && ((count != CW'(DEPTH)) || do_pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            pc_mem[wr_ptr]    <= push_pc;
            instr_mem[wr_ptr] <= push_instr;
        end
    end

    assign valid      = (count != '0);
    assign head_pc    = valid ? pc_mem[rd_ptr]    : '0;
    assign head_instr = valid ? instr_mem[rd_ptr] : '0;

endmodule

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - single-outstanding instruction fetcher feeding a small FIFO
module fetch_buffer
    import riscv_pkg::*;
#(
    parameter int               XLEN     = riscv_pkg::XLEN,
    parameter int               DEPTH    = 4,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     redirect_valid,
    input  logic [XLEN-1:0]          redirect_pc,
    output logic                     imem_req,
    output logic [XLEN-1:0]          imem_addr,
    input  logic                     imem_ack,
    input  logic [31:0]              imem_rdata,
    output logic                     if_valid,
    input  logic                     if_ready,
    output logic [31:0]              if_instr,
    output logic [XLEN-1:0]          if_pc,
    output logic [$clog2(DEPTH):0]   if_count
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t    state;
    fetch_state_t    state_next;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] target_pc;
    logic [XLEN-1:0] redirect_aligned;
    logic            acked;
    logic            push;
    logic            pop;
    logic [CW-1:0]   count_next;
    logic            credit;

    assign redirect_aligned = redirect_pc & ~XLEN'(3);
    assign acked = imem_req && imem_ack;
    assign push  = acked && (state == ST_FETCH) && !redirect_valid;
    assign pop   = if_valid && if_ready && !redirect_valid;

    // Occupancy after this edge; a new request needs a free slot for its eventual push.
    always_comb begin
        count_next = '0;
        if (!redirect_valid) count_next = if_count + CW'(push) - CW'(pop);
    end
    assign credit = (count_next < CW'(DEPTH));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (credit) state_next = ST_FETCH;
            ST_FETCH: begin
                if (acked)               state_next = (redirect_valid || credit) ? ST_FETCH : ST_IDLE;
                else if (redirect_valid) state_next = ST_DRAIN;
            end
            ST_DRAIN: if (acked) state_next = ST_FETCH;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        imem_req  = 1'b0;
        imem_addr = fetch_pc;
        if (state != ST_IDLE) imem_req = 1'b1;
    end

    // fetch_pc is the live request address; target_pc parks a redirect until a drained ack.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc  <= RESET_PC;
            target_pc <= RESET_PC;
        end else begin
            case (state)
                ST_IDLE: if (redirect_valid) fetch_pc <= redirect_aligned;
                ST_FETCH: begin
                    if (acked)               fetch_pc  <= redirect_valid ? redirect_aligned : fetch_pc + XLEN'(4);
                    else if (redirect_valid) target_pc <= redirect_aligned;
                end
                ST_DRAIN: begin
                    if (acked)               fetch_pc  <= redirect_valid ? redirect_aligned : target_pc;
                    else if (redirect_valid) target_pc <= redirect_aligned;
                end
                default: ;
            endcase
        end
    end

    fetch_fifo #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .flush      (redirect_valid),
        .push       (push),
        .push_pc    (fetch_pc),
        .push_instr (imem_rdata),
        .pop        (pop),
        .valid      (if_valid),
        .head_pc    (if_pc),
        .head_instr (if_instr),
        .count      (if_count)
    );

endmodule

// File: tb/tb_fetch_buffer.sv
// tb/tb_fetch_buffer.sv - directed self-checking bench for fetch_buffer
module tb_fetch_buffer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [31:0] if_instr;
    logic [63:0] if_pc;
    logic [2:0]  if_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Memory returns a word derived from its address so each PC has a known instruction.
    assign imem_rdata = imem_addr[31:0] ^ 32'hDEAD_0000;

    fetch_buffer #(
        .XLEN     (64),
        .DEPTH    (4),
        .RESET_PC (64'h0)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_count       (if_count)
    );

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        imem_ack = 1'b0;
        if_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    function automatic logic [31:0] word_at(input logic [63:0] a);
        return a[31:0] ^ 32'hDEAD_0000;
    endfunction

    initial begin
        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_req",   64'(imem_req), 64'd0);
        check("rst_addr",  imem_addr, 64'h0);
        check("rst_valid", 64'(if_valid), 64'd0);
        check("rst_instr", 64'(if_instr), 64'd0);
        check("rst_pc",    if_pc, 64'h0);
        check("rst_count", 64'(if_count), 64'd0);

        // Streaming: ack tied high, consumer always ready
        imem_ack = 1'b1;
        if_ready = 1'b1;
        reset = 1'b1;
        step();
        check("s1_first_req",  64'(imem_req), 64'd1);
        check("s1_first_addr", imem_addr, 64'h0);
        check("s1_first_nov",  64'(if_valid), 64'd0);
        for (int k = 0; k < 4; k++) begin
            step();
            check("s1_addr",  imem_addr, 64'(4 * (k + 1)));
            check("s1_valid", 64'(if_valid), 64'd1);
            check("s1_pc",    if_pc, 64'(4 * k));
            check("s1_instr", 64'(if_instr), 64'(word_at(64'(4 * k))));
            check("s1_count", 64'(if_count), 64'd1);
        end

        // Back-pressure: FIFO fills to 4 and fetching stops
        do_reset();
        imem_ack = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check("s2_req",  64'(imem_req), 64'd1);
            check("s2_addr", imem_addr, 64'(4 * k));
        end
        step();
        check("s2_full_req",   64'(imem_req), 64'd0);
        check("s2_full_count", 64'(if_count), 64'd4);
        check("s2_full_pc",    if_pc, 64'h0);
        step();
        check("s2_hold_req",   64'(imem_req), 64'd0);
        check("s2_hold_count", 64'(if_count), 64'd4);
        if_ready = 1'b1;
        step();
        check("s2_resume_req",   64'(imem_req), 64'd1);
        check("s2_resume_addr",  imem_addr, 64'h10);
        check("s2_resume_count", 64'(if_count), 64'd3);
        check("s2_resume_pc",    if_pc, 64'h4);

        // Redirect while a slow request is outstanding
        do_reset();
        if_ready = 1'b1;
        step();
        check("s3_req", 64'(imem_req), 64'd1);
        redirect_valid = 1'b1;
        redirect_pc = 64'h100;
        step();
        redirect_valid = 1'b0;
        check("s3_wait1_req",  64'(imem_req), 64'd1);
        check("s3_wait1_addr", imem_addr, 64'h0);
        step();
        check("s3_wait2_addr", imem_addr, 64'h0);
        imem_ack = 1'b1;
        step();
        check("s3_redir_addr",  imem_addr, 64'h100);
        check("s3_redir_req",   64'(imem_req), 64'd1);
        check("s3_discard_val", 64'(if_valid), 64'd0);
        check("s3_discard_cnt", 64'(if_count), 64'd0);
        step();
        check("s3_first_valid", 64'(if_valid), 64'd1);
        check("s3_first_pc",    if_pc, 64'h100);
        check("s3_first_instr", 64'(if_instr), 64'(word_at(64'h100)));
        check("s3_next_addr",   imem_addr, 64'h104);

        // Redirect in the same cycle as an ack, unaligned target
        redirect_valid = 1'b1;
        redirect_pc = 64'h203;
        step();
        redirect_valid = 1'b0;
        check("s4_flush_valid", 64'(if_valid), 64'd0);
        check("s4_flush_count", 64'(if_count), 64'd0);
        check("s4_flush_pc",    if_pc, 64'h0);
        check("s4_addr",        imem_addr, 64'h200);
        step();
        check("s4_first_pc", if_pc, 64'h200);

        // Address wrap at the top of the space
        redirect_valid = 1'b1;
        redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        check("s5_top_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        step();
        check("s5_wrap_addr", imem_addr, 64'h0);
        check("s5_top_pc",    if_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        step();
        check("s5_after_addr", imem_addr, 64'h4);
        check("s5_zero_pc",    if_pc, 64'h0);

        // Asynchronous reset while a request is pending and two entries are queued
        do_reset();
        imem_ack = 1'b1;
        repeat (3) step();
        imem_ack = 1'b0;
        step();
        check("s6_pre_req",   64'(imem_req), 64'd1);
        check("s6_pre_count", 64'(if_count), 64'd2);
        check("s6_pre_addr",  imem_addr, 64'h8);
        imem_ack = 1'b1;
        reset = 1'b0;
        #1;
        check("s6_rst_req",   64'(imem_req), 64'd0);
        check("s6_rst_addr",  imem_addr, 64'h0);
        check("s6_rst_valid", 64'(if_valid), 64'd0);
        check("s6_rst_count", 64'(if_count), 64'd0);
        check("s6_rst_instr", 64'(if_instr), 64'd0);
        check("s6_rst_pc",    if_pc, 64'h0);
        step();
        imem_ack = 1'b0;
        reset = 1'b1;
        step();
        check("s6_first_req",   64'(imem_req), 64'd1);
        check("s6_first_addr",  imem_addr, 64'h0);
        check("s6_first_count", 64'(if_count), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_buffer.md
FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 Parameter XLEN, 64, address/PC width.
REQ-002 Parameter DEPTH, 4, instruction FIFO entries (power of two, >=2).
REQ-003 Parameter RESET_PC, 64'h0, first fetch address after reset.
REQ-004 clk  input  1  sole clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 redirect_valid  input  1  taken branch/jump from datapath; flush and refetch.
REQ-007 redirect_pc  input  XLEN  new fetch target.
REQ-008 imem_req  output  1  fetch request to instruction memory.
REQ-009 imem_addr  output  XLEN  fetch address, word aligned.
REQ-010 imem_ack  input  1  memory accepts request; imem_rdata valid same cycle.
REQ-011 imem_rdata  input  32  fetched instruction word.
REQ-012 if_valid  output  1  FIFO head holds a valid instruction.
REQ-013 if_ready  input  1  datapath consumes head this cycle.
REQ-014 if_instr  output  32  head instruction.
REQ-015 if_pc  output  XLEN  PC of head instruction.
REQ-016 if_count  output  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-017 At most one outstanding fetch; handshake completes on cycle with imem_req && imem_ack.
REQ-018 While imem_req is high without ack, imem_addr SHALL stay stable and imem_req SHALL not drop.
REQ-019 New request issued only when if_count + pending_after_this_cycle < DEPTH, so FIFO never overflows.
REQ-020 Memory holding imem_ack high SHALL yield one fetch per cycle (back-to-back requests, fetch_pc += 4).
REQ-021 fetch_pc increments by 4 modulo 2^XLEN; 64'hFFFF_FFFF_FFFF_FFFC wraps to 0.
REQ-022 States: IDLE (no request), FETCH (imem_req high), DRAIN (in-flight request whose data SHALL be discarded).
REQ-023 IDLE->FETCH when credit available; FETCH->IDLE on ack with no credit; FETCH->DRAIN on redirect without ack; DRAIN->FETCH on ack.
REQ-024 On ack, {fetch_pc, imem_rdata} pushed to FIFO unless discarded; push latency one cycle (if_valid earliest the cycle after ack).
REQ-025 Pop occurs when if_valid && if_ready; simultaneous push and pop SHALL keep if_count unchanged.
REQ-026 redirect_valid flushes FIFO that cycle; if_valid low the following cycle; redirect outranks push and pop.
REQ-027 Redirect with ack in the same cycle: returned data discarded, next request at redirect_pc the following cycle.
REQ-028 Redirect during DRAIN: latest redirect_pc replaces the pending target.
REQ-029 redirect_pc bits [1:0] SHALL be forced to zero before use.
REQ-030 if_instr/if_pc SHALL be 0 when if_valid is low.

Reset
REQ-031 Reset asserted: state IDLE, fetch_pc=RESET_PC, FIFO empty, imem_req=0, imem_addr=RESET_PC, if_valid=0, if_instr=0, if_pc=0, if_count=0.
REQ-032 First request (imem_req=1, imem_addr=RESET_PC) SHALL appear in the first cycle after reset deasserts.
REQ-033 Reset mid-request SHALL drop imem_req immediately; late ack after reset SHALL be ignored.

Structure
REQ-034 riscv_pkg SHALL hold XLEN, NOP encoding 32'h0000_0013, and the fetch state enum.
REQ-035 FIFO SHALL be a sub-module fetch_fifo (storage, pointers, count, flush input).

Verification
REQ-036 Reset release, ack tied high, if_ready=1 -> imem_addr 0,4,8,...; if_pc 0 one cycle after first ack, one instruction per cycle.
REQ-037 if_ready=0, ack tied high -> exactly 4 fetches (0..C), imem_req low, if_count=4; then if_ready=1 -> fetching resumes at 0x10.
REQ-038 Ack delay 3 cycles, redirect_pc=0x100 in cycle 1 of wait -> imem_addr holds 0x0 until ack, data discarded, next req at 0x100, first if_pc=0x100.
REQ-039 Redirect_pc=0x203 same cycle as ack -> FIFO empty next cycle, next imem_addr=0x200.
REQ-040 Redirect to 0xFFFF_FFFF_FFFF_FFFC -> fetches FFFC then 0x0.
REQ-041 Reset asserted while imem_req high with FIFO at 2 -> all outputs at reset values, if_count=0, next req at RESET_PC.
